// File: rtl/sensor_cond_if.sv
// ============================================================================
//  Module      : sensor_cond_if
//  Description : Signal bundle between the raw sensor front end and the
//                sensor-conditioning stage (cadence pin, torque and current
//                samples in; conditioned cadence, averages and idle flag out).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface sensor_cond_if;
   logic        cadence_raw;
   logic [11:0] torque;
   logic [11:0] curr;
   logic [4:0]  cadence_vec;
   logic [11:0] avg_torque;
   logic [11:0] avg_curr;
   logic        not_pedaling;

   // Sensor / stimulus side: drives raw samples, observes conditioned values
   modport master (
      output cadence_raw, torque, curr,
      input  cadence_vec, avg_torque, avg_curr, not_pedaling
   );

   // Conditioning stage side
   modport slave (
      input  cadence_raw, torque, curr,
      output cadence_vec, avg_torque, avg_curr, not_pedaling
   );
endinterface

`default_nettype wire

// File: rtl/sensor_cond.sv
// ============================================================================
//  Module      : sensor_cond
//  Description : Debounces the pedal cadence pin into a windowed rising-edge
//                count, averages torque once per cadence pulse (weight 1/32)
//                and averages motor current on a fixed period (weight 1/4).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sensor_cond #(
   parameter int DEB_CYC  = 1024,
   parameter int WIN_CYC  = 4194304,
   parameter int CURR_PER = 4096
) (
   input wire          clk,
   input wire          rst_n,
   sensor_cond_if.slave bus
);

   localparam int DEB_W = (DEB_CYC  > 2) ? $clog2(DEB_CYC)  : 1;
   localparam int WIN_W = (WIN_CYC  > 2) ? $clog2(WIN_CYC)  : 1;
   localparam int CU_W  = (CURR_PER > 2) ? $clog2(CURR_PER) : 1;

   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYC - 1);
   localparam logic [CU_W-1:0]  CU_LAST  = CU_W'(CURR_PER - 1);

   logic             cad_meta;
   logic             cad_sync;
   logic             cad_filt;
   logic             cad_filt_d;
   logic [DEB_W-1:0] deb_cnt;
   logic             cad_rise;

   logic [WIN_W-1:0] win_cnt;
   logic             win_last;
   logic [4:0]       rise_cnt;
   logic [5:0]       rise_sum;
   logic [4:0]       rise_sat;
   logic [4:0]       cadence_vec;

   logic [16:0]      tq_acc;
   logic [16:0]      tq_next;
   logic [CU_W-1:0]  cu_cnt;
   logic             cu_last;
   logic [13:0]      cu_acc;
   logic [13:0]      cu_next;

   // Two-flop synchronizer for the asynchronous cadence pin
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cad_meta <= 1'b0;
         cad_sync <= 1'b0;
      end else begin
         cad_meta <= bus.cadence_raw;
         cad_sync <= cad_meta;
      end
   end

   // Debounce: accept a new level only after DEB_CYC consecutive mismatching cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cad_filt <= 1'b0;
         deb_cnt  <= '0;
      end else if (cad_sync != cad_filt) begin
         if (deb_cnt == DEB_LAST) begin
            cad_filt <= cad_sync;
            deb_cnt  <= '0;
         end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
         end
      end else begin
         deb_cnt <= '0;
      end
   end

   // Delayed copy of the filtered level for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cad_filt_d <= 1'b0;
      end else begin
         cad_filt_d <= cad_filt;
      end
   end

   assign cad_rise = cad_filt & ~cad_filt_d;

   // Saturating rise count including a rise in the current cycle
   assign win_last = (win_cnt == WIN_LAST);
   assign rise_sum = {1'b0, rise_cnt} + {5'b0, cad_rise};
   assign rise_sat = rise_sum[5] ? 5'd31 : rise_sum[4:0];

   // Cadence window: count rises, publish the total on the terminal cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_cnt     <= '0;
         rise_cnt    <= '0;
         cadence_vec <= '0;
      end else begin
         if (win_last) begin
            win_cnt     <= '0;
            rise_cnt    <= '0;
            cadence_vec <= rise_sat;
         end else begin
            win_cnt <= win_cnt + WIN_W'(1);
            if (cad_rise) begin
               rise_cnt <= rise_sat;
            end
         end
      end
   end

   // acc - acc/32 + sample stays below 2^17 because acc/32 tracks the sample range
   assign tq_next = tq_acc - {5'b0, tq_acc[16:5]} + {5'b0, bus.torque};

   // Torque average advances only on cadence pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tq_acc <= '0;
      end else if (cad_rise) begin
         tq_acc <= tq_next;
      end
   end

   assign cu_last = (cu_cnt == CU_LAST);
   assign cu_next = cu_acc - {2'b0, cu_acc[13:2]} + {2'b0, bus.curr};

   // Current average advances once per CURR_PER clocks
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cu_cnt <= '0;
         cu_acc <= '0;
      end else if (cu_last) begin
         cu_cnt <= '0;
         cu_acc <= cu_next;
      end else begin
         cu_cnt <= cu_cnt + CU_W'(1);
      end
   end

   assign bus.cadence_vec  = cadence_vec;
   assign bus.avg_torque   = tq_acc[16:5];
   assign bus.avg_curr     = cu_acc[13:2];
   assign bus.not_pedaling = (cadence_vec < 5'd2);

endmodule

`default_nettype wire

// File: tb/tb_sensor_cond.sv
// ============================================================================
//  Module      : tb_sensor_cond
//  Description : Scoreboard bench for sensor_cond (DEB_CYC=4, WIN_CYC=256,
//                CURR_PER=16). Expected values are queued with the cycle at
//                which they must hold; a monitor compares them on falling edges.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sensor_cond;

   localparam int SIG_CV = 0;
   localparam int SIG_AT = 1;
   localparam int SIG_AC = 2;
   localparam int SIG_NP = 3;

   typedef struct {
      int    cyc;
      int    sig;
      int    exp;
      string name;
   } exp_t;

   logic  clk;
   logic  rst_n;
   int    cyc;
   int    n_tests;
   int    n_fail;
   int    prev_ac;
   exp_t  sb[$];

   sensor_cond_if bus ();

   sensor_cond #(
      .DEB_CYC  (4),
      .WIN_CYC  (256),
      .CURR_PER (16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bench cycle counter, aligned with the DUT's post-reset edge count
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   function automatic void check(string name, int act, int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endfunction

   function automatic int sample(int s);
      case (s)
         SIG_CV:  return int'(bus.cadence_vec);
         SIG_AT:  return int'(bus.avg_torque);
         SIG_AC:  return int'(bus.avg_curr);
         default: return int'(bus.not_pedaling);
      endcase
   endfunction

   function automatic void expect_at(int c, int s, int e, string n);
      exp_t x;
      x.cyc  = c;
      x.sig  = s;
      x.exp  = e;
      x.name = n;
      sb.push_back(x);
   endfunction

   // Monitor: compare due expectations; avg_curr may change only on 16th edges
   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc < cyc) begin
               check({sb[i].name, " not sampled"}, cyc, sb[i].cyc);
               sb.delete(i);
            end else if (sb[i].cyc == cyc) begin
               check(sb[i].name, sample(sb[i].sig), sb[i].exp);
               sb.delete(i);
            end
         end
         if (int'(bus.avg_curr) != prev_ac)
            check("avg_curr update phase", cyc % 16, 0);
      end
      prev_ac = int'(bus.avg_curr);
   end

   task automatic step(int n);
      repeat (n) @(negedge clk);
   endtask

   // Square wave on the cadence pin: n_half half-periods of `half` cycles, starting high
   task automatic wave(int half, int n_half);
      for (int m = 0; m < n_half; m++) begin
         bus.cadence_raw = (m % 2 == 0);
         step(half);
      end
      bus.cadence_raw = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      n_tests         = 0;
      n_fail          = 0;
      prev_ac         = 0;
      rst_n           = 1'b0;
      bus.cadence_raw = 1'b0;
      bus.torque      = 12'h800;
      bus.curr        = 12'h400;

      // Reset state, current average ramp, glitch reject, single rise, 8/window, stop, saturation
      expect_at(1,     SIG_CV, 0,     "reset cadence_vec");
      expect_at(1,     SIG_AT, 0,     "reset avg_torque");
      expect_at(1,     SIG_AC, 0,     "reset avg_curr");
      expect_at(1,     SIG_NP, 1,     "reset not_pedaling");
      expect_at(15,    SIG_AC, 0,     "avg_curr before first update");
      expect_at(16,    SIG_AC, 'h100, "avg_curr first update");
      expect_at(31,    SIG_AC, 'h100, "avg_curr held");
      expect_at(32,    SIG_AC, 'h1C0, "avg_curr second update");
      expect_at(100,   SIG_AT, 0,     "glitch no torque update");
      expect_at(256,   SIG_CV, 0,     "glitch cadence_vec");
      expect_at(256,   SIG_NP, 1,     "glitch not_pedaling");
      expect_at(320,   SIG_AT, 'h040, "avg_torque one rise of 0x800");
      expect_at(511,   SIG_CV, 0,     "cadence_vec held before terminal");
      expect_at(512,   SIG_CV, 1,     "cadence_vec single rise");
      expect_at(512,   SIG_NP, 1,     "not_pedaling at count 1");
      expect_at(530,   SIG_AT, 'h0BD, "avg_torque first 0xFFF rise");
      expect_at(560,   SIG_AT, 'h138, "avg_torque second 0xFFF rise");
      expect_at(768,   SIG_CV, 8,     "cadence_vec 32-cycle wave w2");
      expect_at(1024,  SIG_CV, 8,     "cadence_vec 32-cycle wave w3");
      expect_at(1024,  SIG_NP, 0,     "not_pedaling while pedaling");
      expect_at(1792,  SIG_CV, 8,     "cadence_vec 32-cycle wave last");
      expect_at(2000,  SIG_AC, 'h400, "avg_curr converged");
      expect_at(2047,  SIG_CV, 8,     "cadence_vec held after stop");
      expect_at(2048,  SIG_CV, 0,     "cadence_vec after stop window");
      expect_at(2048,  SIG_NP, 1,     "not_pedaling after stop");
      expect_at(2304,  SIG_CV, 25,    "cadence_vec partial fast window");
      expect_at(2560,  SIG_CV, 31,    "cadence_vec saturated");
      expect_at(2560,  SIG_NP, 0,     "not_pedaling saturated");
      expect_at(5120,  SIG_CV, 31,    "cadence_vec saturated later");
      expect_at(10950, SIG_AT, 'hFFF, "avg_torque full scale no wrap");

      step(3);
      rst_n = 1'b1;                     // cycle 0

      step(10);                         // cycle 10: 3-cycle glitch
      bus.cadence_raw = 1'b1;
      step(3);
      bus.cadence_raw = 1'b0;

      step(287);                        // cycle 300: one clean pulse
      bus.cadence_raw = 1'b1;
      step(20);
      bus.cadence_raw = 1'b0;
      step(20);                         // cycle 340
      bus.torque = 12'hFFF;

      step(180);                        // cycle 520: 16 high / 16 low
      wave(16, 80);                     // ends at cycle 1800

      step(300);                        // cycle 2100: 4 high / 4 low
      wave(4, 2200);                    // ends at cycle 10900

      step(100);                        // cycle 11000: reset mid-debounce
      bus.cadence_raw = 1'b1;
      step(2);
      #2;
      rst_n = 1'b0;
      #1;
      check("async reset cadence_vec",  sample(SIG_CV), 0);
      check("async reset avg_torque",   sample(SIG_AT), 0);
      check("async reset avg_curr",     sample(SIG_AC), 0);
      check("async reset not_pedaling", sample(SIG_NP), 1);
      check("scoreboard drained before reset", sb.size(), 0);
      sb.delete();

      // After release the first window must be a full 256 cycles
      expect_at(5,   SIG_AT, 0,     "post-reset avg_torque before rise");
      expect_at(10,  SIG_AT, 'h07F, "post-reset avg_torque first rise");
      expect_at(15,  SIG_AC, 0,     "post-reset avg_curr before update");
      expect_at(16,  SIG_AC, 'h100, "post-reset avg_curr first update");
      expect_at(255, SIG_CV, 0,     "post-reset cadence_vec before window");
      expect_at(256, SIG_CV, 8,     "post-reset first full window");
      expect_at(256, SIG_NP, 0,     "post-reset not_pedaling");

      step(3);
      rst_n = 1'b1;                     // cycle 0 again
      wave(16, 20);
      step(20);

      check("scoreboard drained at end", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/sensor_cond.md
# sensor_cond

Sensor-conditioning stage that sits directly upstream of the desired-drive calculation. It debounces the raw pedal cadence pin and converts it to a windowed cadence count `cadence_vec`. It exponentially averages the raw torque sample into `avg_torque`, updating once per cadence pulse. It also averages motor current into `avg_curr` on a fixed sample period for the downstream current loop.

## Interface
- `DEB_CYC`, default 1024: consecutive cycles a changed cadence level must persist before it is accepted (≥2).
- `WIN_CYC`, default 4194304: length in clocks of one cadence counting window (≥2).
- `CURR_PER`, default 4096: clocks between current-average updates (≥2).
- `clk`  input  1  system clock, all state on rising edge.
- `rst_n`  input  1  reset; asynchronous, active-low.
- `cadence_raw`  input  1  raw asynchronous cadence sensor pin.
- `torque`  input  12  unsigned raw torque sample, synchronous to `clk`.
- `curr`  input  12  unsigned raw motor-current sample, synchronous to `clk`.
- `cadence_vec`  output  5  rising edges counted in the last completed window, saturated at 31.
- `avg_torque`  output  12  exponential average of `torque`, weight 1/32.
- `avg_curr`  output  12  exponential average of `curr`, weight 1/4.
- `not_pedaling`  output  1  high when `cadence_vec` < 2.

## Operation
- Synchronizer: `cadence_raw` passes through 2 flops to give `cad_sync`.
- Debounce: `deb_cnt` increments each cycle with `cad_sync` != `cad_filt`, and clears on any cycle where they are equal.
  - When a mismatch occurs with `deb_cnt` == DEB_CYC-1, `cad_filt` takes `cad_sync` and `deb_cnt` clears.
  - A glitch shorter than DEB_CYC cycles never changes `cad_filt`.
- `cad_rise` is high for exactly one cycle after `cad_filt` goes 0→1, formed from `cad_filt` and its 1-cycle delayed copy.
- Cadence window:
  - `win_cnt` counts 0..WIN_CYC-1 and wraps.
  - `rise_cnt` (5 bits) increments on `cad_rise` and saturates at 31.
  - On the terminal cycle (`win_cnt` == WIN_CYC-1), `cadence_vec` loads min(`rise_cnt` + `cad_rise`, 31) and `rise_cnt` clears to 0. A rise on the terminal cycle counts in the closing window.
- Torque average: 17-bit `tq_acc` holds 32×average.
  - On each `cad_rise`: `tq_acc` ← `tq_acc` − `tq_acc`[16:5] + `torque`.
  - `avg_torque` = `tq_acc`[16:5].
  - `tq_acc` is held when `cad_rise` is low, and never overflows (maximum 131071).
- Current average: 14-bit `cu_acc` holds 4×average.
  - `cu_cnt` counts 0..CURR_PER-1 and wraps.
  - On the terminal cycle: `cu_acc` ← `cu_acc` − `cu_acc`[13:2] + `curr`.
  - `avg_curr` = `cu_acc`[13:2].
- `not_pedaling` is combinational from the `cadence_vec` register.

## Timing
- Reset (`rst_n` low, asynchronous): all counters, `cad_sync` flops, `cad_filt`, accumulators and `cadence_vec` go to 0. Outputs read `cadence_vec`=0, `avg_torque`=0, `avg_curr`=0, `not_pedaling`=1.
- Reset asserted mid-window or mid-debounce discards all partial counts. After release, the first window is a full WIN_CYC clocks.
- Latency from a `cadence_raw` transition (stable thereafter) to `cad_filt` changing: DEB_CYC+2 clock edges.
- `cad_rise` is asserted in the cycle after `cad_filt` rises. `tq_acc` and `rise_cnt` update at the edge ending that cycle.
- `cadence_vec` changes only at a window terminal edge and holds for the following WIN_CYC cycles.
- `torque` is sampled only in `cad_rise` cycles. `curr` is sampled only in `cu_cnt` terminal cycles.
- A falling edge of `cad_filt` has no effect besides debounce.
- `rise_cnt` saturation: further rises in the same window are ignored.

## Test plan
- Reset: assert `rst_n`=0 mid-operation, with no clock edge required → `cadence_vec`=0, `avg_torque`=0, `avg_curr`=0, `not_pedaling`=1 immediately.
- Glitch reject, DEB_CYC=4: `cadence_raw` high for 3 cycles then low → `cad_filt` stays 0, no `cad_rise`, `cadence_vec`=0 after the window.
- Cadence count, DEB_CYC=4, WIN_CYC=256: 32-cycle square wave (16 high / 16 low) → `cadence_vec`=8 from the second window onward, `not_pedaling`=0. Stop the wave → `cadence_vec`=0 and `not_pedaling`=1 after one full window.
- Saturation, WIN_CYC=512: 10-cycle wave (5 high / 5 low) → `cadence_vec`=31.
- Torque average: from reset, `torque`=12'h800 with one rise → `avg_torque`=12'h040. Then `torque`=12'hFFF for 1000 rises → `avg_torque`=12'hFFF, no wrap.
- Current average, CURR_PER=16: `curr`=12'h400 → `avg_curr`=12'h100 after the first terminal cycle, 12'h1C0 after the second, converging to 12'h400. `avg_curr` changes only on every 16th edge.
